dense_argmax_collect: RTL and testbench
=======================================

DENSE_ARGMAX_COLLECT -- requirements
Module: dense_argmax_collect

Interface
REQ-001 SHALL have parameter BIT_Z, default `BIT_SOFTMAX, width of a signed class score.
REQ-002 SHALL have parameter BIT_IDX, default `BIT_O, width of a class index.
REQ-003 SHALL have parameter NUM_CLASS, default 10, number of score tokens per frame (2..2^BIT_IDX).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 Ports, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- zt, zf  in  BIT_Z  dual-rail score from the dense stage.
- index_t, index_f  in  BIT_IDX  dual-rail class index from the dense stage.
- ack_prev  out  1  four-phase acknowledge to the dense stage.
- early_en  in  1  enables early termination.
- thresh  in  BIT_Z  signed early-termination threshold.
- valid_o  out  1  result available.
- ack_nxt  in  1  consumer accepted result.
- class_o  out  BIT_IDX  winning class index.
- score_o  out  BIT_Z  winning score, signed.
- early_o  out  1  result was produced by early termination.
- err_o  out  1  sticky protocol error.

Function
REQ-006 Codeword SHALL be complete when (zt^zf) and (index_t^index_f) are all ones; spacer when zt, zf, index_t and index_f are all zero; anything else is in transition and ignored.
REQ-007 Any bit position with both rails high SHALL set err_o on the next edge; err_o clears only on reset.
REQ-008 FSM states: S_DATA (wait for a complete codeword), S_SPACER (ack_prev high, wait for spacer), S_HOLD (frame done, wait for the result to be accepted).
REQ-009 S_DATA + complete codeword at edge N: ack_prev=1 from N+1; token decoded (score=zt, idx=index_t); tok_cnt incremented; go to S_SPACER.
REQ-010 S_SPACER + spacer at edge M: ack_prev=0 from M+1; if tok_cnt==NUM_CLASS then tok_cnt<=0 and go to S_HOLD if valid_o=1, else go to S_DATA; otherwise go to S_DATA.
REQ-011 The first token of a frame SHALL load best_score/best_idx unconditionally.
REQ-012 Each later token SHALL replace best only if score > best_score (signed, strict); ties keep the earlier index.
REQ-013 When a token arrives while undecided and early_en=1 and the token score >= thresh (signed), the frame SHALL be decided: class_o/score_o = that token, early_o=1, valid_o=1, all one cycle after capture.
REQ-014 When the last token (tok_cnt reaches NUM_CLASS) arrives undecided, the updated best SHALL be published with early_o=0 and valid_o=1, one cycle after capture.
REQ-015 After a decision, remaining tokens of the frame SHALL still be handshaken but SHALL NOT alter class_o, score_o or early_o (drain).
REQ-016 valid_o SHALL stay high, with outputs stable, until sampled with ack_nxt=1; it clears on the following edge.
REQ-017 S_HOLD + ack_nxt=1: valid_o<=0, go to S_DATA; no new-frame token is accepted while valid_o=1 at frame end.
REQ-018 A decision and ack_nxt=1 on the same edge SHALL keep valid_o=1 (new result wins).
REQ-019 Codeword values SHALL be sampled only in S_DATA; stale codewords in S_SPACER are ignored.

Reset
REQ-020 reset=0 at an edge SHALL clear ack_prev, valid_o, class_o, score_o, early_o, err_o, tok_cnt, best and the decided flag, and go to S_DATA, overriding every other event including mid-frame operation.
REQ-021 After release, the first complete codeword SHALL be treated as token 0 of a new frame.

Verification (BIT_Z=16, BIT_IDX=4, NUM_CLASS=10)
REQ-022 Reset held 2 cycles, then released -> all outputs 0, ack_prev=0, state S_DATA.
REQ-023 early_en=0, scores 5,-3,40,40,7,0,12,-100,39,1 on idx 0..9 -> valid_o=1, class_o=2, score_o=40, early_o=0 one cycle after the 10th capture.
REQ-024 early_en=1, thresh=30, same scores -> valid_o=1 after idx 2 with class_o=2, score_o=40, early_o=1; idx 3..9 still acked; outputs unchanged.
REQ-025 Result held with ack_nxt=0 for 5 cycles while the next frame's codeword is present -> ack_prev stays 0, no capture; ack_nxt=1 -> valid_o=0 next edge, then the token is captured.
REQ-026 Token with zt[3]=zf[3]=1 -> err_o=1 next edge and stays 1 until reset; reset asserted during token 4 -> tok_cnt=0, ack_prev=0.

Source files
------------

// File: rtl/dense_argmax_collect.sv
// Dual-rail argmax collector: takes NUM_CLASS four-phase dual-rail score
// tokens per frame from the dense stage and keeps the running best
// (signed, strict '>' so ties keep the earlier index). It publishes the
// winning class either at the last token or as soon as a token reaches the
// early-termination threshold. Tokens left in the frame after a decision
// are still acknowledged but cannot change the published result.
//
// Handshake: valid_o rises with a new result and stays high, outputs stable,
// until an edge samples ack_nxt=1; valid_o drops on that edge unless a new
// decision lands on the same edge. The upstream side is four-phase:
// a complete codeword raises ack_prev, and an all-zero spacer lowers it.
`ifndef BIT_SOFTMAX
`define BIT_SOFTMAX 16
`endif
`ifndef BIT_O
`define BIT_O 4
`endif

module dense_argmax_collect #(
    parameter int BIT_Z     = `BIT_SOFTMAX,
    parameter int BIT_IDX   = `BIT_O,
    parameter int NUM_CLASS = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [BIT_Z-1:0]          zt,
    input  logic [BIT_Z-1:0]          zf,
    input  logic [BIT_IDX-1:0]        index_t,
    input  logic [BIT_IDX-1:0]        index_f,
    output logic                      ack_prev,
    input  logic                      early_en,
    input  logic signed [BIT_Z-1:0]   thresh,
    output logic                      valid_o,
    input  logic                      ack_nxt,
    output logic [BIT_IDX-1:0]        class_o,
    output logic signed [BIT_Z-1:0]   score_o,
    output logic                      early_o,
    output logic                      err_o
);

    // One extra bit so the counter can hold NUM_CLASS == 2^BIT_IDX.
    localparam int CW = BIT_IDX + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CLASS);

    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_SPACER = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           tok_cnt;
    logic signed [BIT_Z-1:0] best_score;
    logic [BIT_IDX-1:0]      best_idx;
    logic                    decided;

    logic                    complete;
    logic                    spacer;
    logic                    clash;
    logic signed [BIT_Z-1:0] tok_score;
    logic                    take_new;
    logic signed [BIT_Z-1:0] nbest_score;
    logic [BIT_IDX-1:0]      nbest_idx;
    logic                    hit_early;
    logic                    hit_last;

    // Codeword classification and the candidate best for the token on the rails.
    always_comb begin
        complete    = (&(zt ^ zf)) && (&(index_t ^ index_f));
        spacer      = (zt == '0) && (zf == '0) && (index_t == '0) && (index_f == '0);
        clash       = (|(zt & zf)) || (|(index_t & index_f));
        tok_score   = $signed(zt);
        take_new    = (tok_cnt == '0) || (tok_score > best_score);
        nbest_score = take_new ? tok_score : best_score;
        nbest_idx   = take_new ? index_t : best_idx;
        hit_early   = !decided && early_en && (tok_score >= thresh);
        hit_last    = !decided && ((tok_cnt + 1'b1) == LAST);
    end

    // Handshake FSM, running best, result publication and sticky error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_DATA;
            ack_prev   <= 1'b0;
            valid_o    <= 1'b0;
            class_o    <= '0;
            score_o    <= '0;
            early_o    <= 1'b0;
            err_o      <= 1'b0;
            tok_cnt    <= '0;
            best_score <= '0;
            best_idx   <= '0;
            decided    <= 1'b0;
        end else begin
            if (clash) begin
                err_o <= 1'b1;
            end
            // Consumer acceptance; a decision later in this block overrides it.
            if (valid_o && ack_nxt) begin
                valid_o <= 1'b0;
            end
            case (state)
                S_DATA: begin
                    if (complete) begin
                        ack_prev   <= 1'b1;
                        tok_cnt    <= tok_cnt + 1'b1;
                        best_score <= nbest_score;
                        best_idx   <= nbest_idx;
                        state      <= S_SPACER;
                        if (hit_early) begin
                            decided <= 1'b1;
                            class_o <= index_t;
                            score_o <= tok_score;
                            early_o <= 1'b1;
                            valid_o <= 1'b1;
                        end else if (hit_last) begin
                            decided <= 1'b1;
                            class_o <= nbest_idx;
                            score_o <= nbest_score;
                            early_o <= 1'b0;
                            valid_o <= 1'b1;
                        end
                    end
                end
                S_SPACER: begin
                    if (spacer) begin
                        ack_prev <= 1'b0;
                        if (tok_cnt == LAST) begin
                            tok_cnt <= '0;
                            decided <= 1'b0;
                            // An unaccepted result blocks the next frame.
                            state   <= (valid_o && !ack_nxt) ? S_HOLD : S_DATA;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_HOLD: begin
                    if (ack_nxt) begin
                        valid_o <= 1'b0;
                        state   <= S_DATA;
                    end
                end
                default: state <= S_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_argmax_collect.sv
// Directed bench for dense_argmax_collect (BIT_Z=16, BIT_IDX=4, NUM_CLASS=10).
// Expected results {early, class, score} are queued by the driver; a monitor
// pops one whenever valid_o rises and compares it with the published result.
module tb_dense_argmax_collect;

    localparam int BZ = 16;
    localparam int BI = 4;
    localparam int NC = 10;
    localparam int EW = 1 + BI + BZ;

    logic                 clock;
    logic                 reset;
    logic [BZ-1:0]        zt, zf;
    logic [BI-1:0]        index_t, index_f;
    logic                 ack_prev;
    logic                 early_en;
    logic signed [BZ-1:0] thresh;
    logic                 valid_o;
    logic                 ack_nxt;
    logic [BI-1:0]        class_o;
    logic signed [BZ-1:0] score_o;
    logic                 early_o;
    logic                 err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic          prev_valid = 1'b0;

    dense_argmax_collect #(.BIT_Z(BZ), .BIT_IDX(BI), .NUM_CLASS(NC)) dut (
        .clock(clock), .reset(reset),
        .zt(zt), .zf(zf), .index_t(index_t), .index_f(index_f),
        .ack_prev(ack_prev), .early_en(early_en), .thresh(thresh),
        .valid_o(valid_o), .ack_nxt(ack_nxt),
        .class_o(class_o), .score_o(score_o), .early_o(early_o), .err_o(err_o)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Driver tasks
    task automatic drive_code(input int score, input int idx);
        zt      = BZ'(score);
        zf      = ~BZ'(score);
        index_t = BI'(idx);
        index_f = ~BI'(idx);
    endtask

    task automatic drive_spacer();
        zt = '0; zf = '0; index_t = '0; index_f = '0;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (ack_prev === lvl) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: ack_prev never reached %0b", name, lvl);
        end
    endtask

    task automatic send_token(input int score, input int idx);
        drive_code(score, idx);
        wait_ack(1'b1, "ack_rise");
        drive_spacer();
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic accept_result();
        ack_nxt = 1'b1;
        @(negedge clock);
        ack_nxt = 1'b0;
        check("valid_cleared", 32'(valid_o), 32'd0);
    endtask

    function automatic logic [EW-1:0] pack(input logic e, input int c, input int s);
        return {e, BI'(c), BZ'(s)};
    endfunction

    // Scoreboard monitor: compare each new result against the queue head
    always @(negedge clock) begin
        if (valid_o && !prev_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got %0h with empty queue",
                         {early_o, class_o, score_o});
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({early_o, class_o, score_o} !== e) begin
                    n_fail++;
                    $display("FAIL result: got %0h expected %0h",
                             {early_o, class_o, score_o}, e);
                end
            end
        end
        prev_valid <= valid_o;
    end

    int s1[NC] = '{5, -3, 40, 40, 7, 0, 12, -100, 39, 1};
    int s3[NC] = '{7, -20, 7, 8, 8, -5, 0, 3, 8, -1};
    int s4[NC] = '{-20, -10, 50, 1, 2, 3, 4, 5, 6, 7};
    int s5[NC] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};

    initial begin
        reset = 1'b0; ack_nxt = 1'b0; early_en = 1'b0; thresh = '0;
        drive_spacer();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_ack_prev", 32'(ack_prev), 32'd0);
        check("rst_outputs", 32'({valid_o, class_o, score_o, early_o, err_o}), 32'd0);

        // Frame 1: no early termination; tie at idx 3 keeps idx 2
        exp_q.push_back(pack(1'b0, 2, 40));
        for (int i = 0; i < NC; i++) send_token(s1[i], i);
        check("f1_valid_hold", 32'(valid_o), 32'd1);
        accept_result();

        // Frame 2: early termination at idx 2, then drain
        early_en = 1'b1; thresh = 16'sd30;
        exp_q.push_back(pack(1'b1, 2, 40));
        for (int i = 0; i < 3; i++) send_token(s1[i], i);
        check("f2_early_valid", 32'(valid_o), 32'd1);
        for (int i = 3; i < NC; i++) send_token(s1[i], i);
        check("f2_drain_out", 32'({class_o, score_o, early_o}), 32'({4'd2, 16'd40, 1'b1}));

        // Result held while the next frame's first codeword waits
        early_en = 1'b0;
        exp_q.push_back(pack(1'b0, 3, 8));
        drive_code(s3[0], 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_no_ack", 32'({ack_prev, valid_o}), 32'b01);
        end
        ack_nxt = 1'b1;
        @(negedge clock);
        ack_nxt = 1'b0;
        check("hold_release", 32'({ack_prev, valid_o}), 32'b00);
        @(negedge clock);
        check("hold_capture", 32'(ack_prev), 32'd1);
        drive_spacer();
        wait_ack(1'b0, "ack_fall");
        for (int i = 1; i < NC; i++) send_token(s3[i], i);
        accept_result();

        // Frame 4: negative threshold, equality triggers at idx 1
        early_en = 1'b1; thresh = -16'sd10;
        exp_q.push_back(pack(1'b1, 1, -10));
        for (int i = 0; i < NC; i++) send_token(s4[i], i);
        check("f4_drain_out", 32'({class_o, score_o, early_o}), 32'({4'd1, 16'hFFF6, 1'b1}));
        accept_result();

        // Rail clash sets the sticky error
        early_en = 1'b0;
        zt = 16'h0008; zf = 16'h0008; index_t = '0; index_f = '0;
        @(negedge clock);
        check("err_set", 32'(err_o), 32'd1);
        drive_spacer();
        for (int i = 0; i < 4; i++) send_token(s5[i], i);
        check("err_sticky", 32'(err_o), 32'd1);

        // Reset during token 4
        drive_code(s5[4], 4);
        wait_ack(1'b1, "ack_rise");
        reset = 1'b0;
        @(negedge clock);
        drive_spacer();
        @(negedge clock);
        check("midrst_state", 32'({ack_prev, valid_o, err_o}), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Fresh frame after reset: tok_cnt must start at 0
        exp_q.push_back(pack(1'b0, 5, 9));
        for (int i = 0; i < NC; i++) send_token(s5[i], i);
        accept_result();

        repeat (2) @(negedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
